// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on magnitudes, 32 iterations,
// with sign fix-up and special cases applied in FINISH.
// Build option: MULDIV_DIV_EN includes the divider datapath; without it,
// funct3[2]=1 ops skip CALC and write back 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for start; latches op, rd and operand magnitudes
// S_CALC   | one multiply or divide iteration per cycle, 32 in total
// S_FINISH | sign correction, result registered, done pulsed
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   input  logic [4:0]      i_rd_addr,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_wb_we,
   output logic [4:0]      o_wb_addr,
   output logic [XLEN-1:0] o_wb_data
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   state_t            r_state;
   logic [5:0]        r_cnt;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic              r_neg;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_b;

   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic              w_res_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_mul_res;
   logic [XLEN-1:0]   w_div_res;
   logic [XLEN-1:0]   w_result;

   // Operand decode at acceptance: which sources are signed, their magnitudes
   // and the sign the final result must carry (REM follows the dividend).
   assign w_a_signed = (i_funct3 == F_MULH) || (i_funct3 == F_MULHSU) ||
                       (i_funct3 == F_DIV)  || (i_funct3 == F_REM);
   assign w_b_signed = (i_funct3 == F_MULH) || (i_funct3 == F_DIV) || (i_funct3 == F_REM);
   assign w_a_neg    = w_a_signed & i_rs1_val[XLEN-1];
   assign w_b_neg    = w_b_signed & i_rs2_val[XLEN-1];
   assign w_a_mag    = w_a_neg ? (~i_rs1_val + 1'b1) : i_rs1_val;
   assign w_b_mag    = w_b_neg ? (~i_rs2_val + 1'b1) : i_rs2_val;
   assign w_res_neg  = (i_funct3 == F_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

   // Multiply step: {r_hi,r_lo} is the running product with the multiplier
   // shifting out of r_lo; the carry of the add re-enters at the top.
   assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
   logic              r_div0;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_diff;
   logic [XLEN-1:0]   w_quo_fix;
   logic [XLEN-1:0]   w_rem_fix;

   // Restoring divide: r_hi is the partial remainder, r_lo shifts the
   // dividend out and the quotient in. Divide-by-zero naturally leaves the
   // dividend magnitude in r_hi, and 0x80000000/-1 naturally yields the
   // wrapped quotient with a zero remainder; only the quotient of a zero
   // divisor needs overriding.
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b};
   assign w_quo_fix   = r_neg ? (~r_lo + 1'b1) : r_lo;
   assign w_rem_fix   = r_neg ? (~r_hi + 1'b1) : r_hi;
   assign w_div_res   = r_op[1] ? w_rem_fix : (r_div0 ? '1 : w_quo_fix);
`else
   assign w_div_res   = '0;
`endif

   assign w_result = r_op[2] ? w_div_res : w_mul_res;

   // Control FSM with the iteration datapath and registered write-back outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_neg     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
`ifdef MULDIV_DIV_EN
         r_div0    <= 1'b0;
`endif
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_done  <= 1'b0;
               o_wb_we <= 1'b0;
               o_busy  <= i_start;
               if (i_start) begin
                  r_op  <= i_funct3;
                  r_rd  <= i_rd_addr;
                  r_neg <= w_res_neg;
                  r_hi  <= '0;
                  r_lo  <= w_a_mag;
                  r_b   <= w_b_mag;
                  r_cnt <= '0;
`ifdef MULDIV_DIV_EN
                  r_div0  <= (i_rs2_val == '0);
                  r_state <= S_CALC;
`else
                  r_state <= i_funct3[2] ? S_FINISH : S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
               if (r_op[2]) begin
                  if (!w_div_diff[XLEN]) begin
                     r_hi <= w_div_diff[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], 1'b1};
                  end else begin
                     r_hi <= w_div_shift[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], 1'b0};
                  end
               end else begin
                  {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
               end
`else
               {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
`endif
               if (r_cnt == 6'(XLEN - 1)) begin
                  r_state <= S_FINISH;
               end
            end
            S_FINISH: begin
               o_wb_data <= w_result;
               o_wb_addr <= r_rd;
               o_wb_we   <= (r_rd != 5'd0);
               o_done    <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit; divide tests follow MULDIV_DIV_EN.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        done;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_funct3  (funct3),
      .i_rs1_val (rs1_val),
      .i_rs2_val (rs2_val),
      .i_rd_addr (rd_addr),
      .o_busy    (busy),
      .o_done    (done),
      .o_wb_we   (wb_we),
      .o_wb_addr (wb_addr),
      .o_wb_data (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op, scramble operands after acceptance, and wait (bounded)
   // for done; lat counts rising edges from acceptance to the done cycle.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] d,
                         output logic we, output logic [4:0] ad);
      @(negedge clk);
      start   = 1'b1;
      funct3  = f3;
      rs1_val = a;
      rs2_val = b;
      rd_addr = rd;
      @(posedge clk);
      #1;
      start   = 1'b0;
      rs1_val = ~a;
      rs2_val = ~b;
      rd_addr = ~rd;
      funct3  = ~f3;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      d  = wb_data;
      we = wb_we;
      ad = wb_addr;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset done got %b exp 0", done); end
      checks++; if (wb_we !== 1'b0)    begin errors++; $display("FAIL reset wb_we got %b exp 0", wb_we); end
      checks++; if (wb_addr !== 5'd0)  begin errors++; $display("FAIL reset wb_addr got %0d exp 0", wb_addr); end
      checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset wb_data got %h exp 0", wb_data); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [2:0]  vf [7];
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] ve [7];
      int lat; logic [31:0] d; logic we; logic [4:0] ad;
      vf = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b010, 3'b001, 3'b011};
      va = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h80000000, 32'h80000000};
      vb = '{32'd6, 32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
      ve = '{32'd42, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'd1, 32'd1, 32'hC0000000, 32'h40000000};
      for (int i = 0; i < 7; i++) begin
         run_op(vf[i], va[i], vb[i], 5'(i + 5), lat, d, we, ad);
         checks++; if (lat != 33)  begin errors++; $display("FAIL mul[%0d] latency got %0d exp 33", i, lat); end
         checks++; if (d !== ve[i]) begin errors++; $display("FAIL mul[%0d] data got %h exp %h", i, d, ve[i]); end
         checks++; if (we !== 1'b1) begin errors++; $display("FAIL mul[%0d] wb_we got %b exp 1", i, we); end
         checks++; if (ad !== 5'(i + 5)) begin errors++; $display("FAIL mul[%0d] wb_addr got %0d exp %0d", i, ad, i + 5); end
      end
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_div();
      logic [2:0]  vf [14];
      logic [31:0] va [14];
      logic [31:0] vb [14];
      logic [31:0] ve [14];
      int lat; logic [31:0] d; logic we; logic [4:0] ad;
      vf = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
      va = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'd100, 32'd100, 32'd5, 32'd5,
             32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      vb = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7, 32'd0, 32'd0,
             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      ve = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
             32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'd0, 32'd0, 32'h80000000};
      for (int i = 0; i < 14; i++) begin
         run_op(vf[i], va[i], vb[i], 5'(i + 10), lat, d, we, ad);
         checks++; if (lat != 33)  begin errors++; $display("FAIL div[%0d] latency got %0d exp 33", i, lat); end
         checks++; if (d !== ve[i]) begin errors++; $display("FAIL div[%0d] data got %h exp %h", i, d, ve[i]); end
         checks++; if (we !== 1'b1) begin errors++; $display("FAIL div[%0d] wb_we got %b exp 1", i, we); end
      end
   endtask
`else
   task automatic test_div_disabled();
      int lat; logic [31:0] d; logic we; logic [4:0] ad;
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd3, lat, d, we, ad);
      checks++; if (lat != 1)      begin errors++; $display("FAIL nodiv latency got %0d exp 1", lat); end
      checks++; if (d !== 32'd0)   begin errors++; $display("FAIL nodiv data got %h exp 0", d); end
      checks++; if (we !== 1'b1)   begin errors++; $display("FAIL nodiv wb_we got %b exp 1", we); end
      checks++; if (ad !== 5'd3)   begin errors++; $display("FAIL nodiv wb_addr got %0d exp 3", ad); end
      run_op(3'd7, 32'd5, 32'd0, 5'd0, lat, d, we, ad);
      checks++; if (lat != 1)      begin errors++; $display("FAIL nodiv_remu latency got %0d exp 1", lat); end
      checks++; if (we !== 1'b0)   begin errors++; $display("FAIL nodiv_remu wb_we got %b exp 0", we); end
      run_op(3'd0, 32'd4, 32'd5, 5'd9, lat, d, we, ad);
      checks++; if (lat != 33)     begin errors++; $display("FAIL nodiv_mul latency got %0d exp 33", lat); end
      checks++; if (d !== 32'd20)  begin errors++; $display("FAIL nodiv_mul data got %h exp 14", d); end
   endtask
`endif

   task automatic test_rd_zero();
      int lat; logic [31:0] d; logic we; logic [4:0] ad;
      run_op(3'd0, 32'd2, 32'd3, 5'd0, lat, d, we, ad);
      checks++; if (lat != 33)    begin errors++; $display("FAIL rd0 latency got %0d exp 33", lat); end
      checks++; if (d !== 32'd6)  begin errors++; $display("FAIL rd0 data got %h exp 6", d); end
      checks++; if (we !== 1'b0)  begin errors++; $display("FAIL rd0 wb_we got %b exp 0", we); end
   endtask

   task automatic test_start_held();
      int lat;
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held busy got %b exp 1", busy); end
      rs1_val = 32'd5; rs2_val = 32'd5; rd_addr = 5'd2;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 20) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held busy_mid got %b exp 1", busy); end
         end
      end
      start = 1'b0;
      checks++; if (lat != 33)         begin errors++; $display("FAIL held latency got %0d exp 33", lat); end
      checks++; if (wb_data !== 32'd12) begin errors++; $display("FAIL held data got %h exp c", wb_data); end
      checks++; if (wb_addr !== 5'd1)  begin errors++; $display("FAIL held wb_addr got %0d exp 1", wb_addr); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL held busy_done got %b exp 1", busy); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL held done_pulse got %b exp 0", done); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL held busy_end got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] d; logic we; logic [4:0] ad;
      run_op(3'd0, 32'd11, 32'd13, 5'd20, lat, d, we, ad);
      checks++; if (d !== 32'd143) begin errors++; $display("FAIL b2b first data got %h exp 8f", d); end
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, lat, d, we, ad);
      checks++; if (lat != 33)     begin errors++; $display("FAIL b2b second latency got %0d exp 33", lat); end
      checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b second data got %h exp fffffffe", d); end
      checks++; if (ad !== 5'd21)  begin errors++; $display("FAIL b2b second wb_addr got %0d exp 21", ad); end
   endtask

   task automatic test_reset_mid_calc();
      int lat; int seen; logic [31:0] d; logic we; logic [4:0] ad;
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_addr = 5'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst busy got %b exp 0", busy); end
      checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL midrst wb_data got %h exp 0", wb_data); end
      checks++; if (wb_addr !== 5'd0)  begin errors++; $display("FAIL midrst wb_addr got %0d exp 0", wb_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst activity got %0d cycles exp 0", seen); end
      run_op(3'd0, 32'd9, 32'd9, 5'd4, lat, d, we, ad);
      checks++; if (lat != 33)    begin errors++; $display("FAIL midrst next latency got %0d exp 33", lat); end
      checks++; if (d !== 32'd81) begin errors++; $display("FAIL midrst next data got %h exp 51", d); end
   endtask

   initial begin
      test_reset();
      test_mul();
`ifdef MULDIV_DIV_EN
      test_div();
`else
      test_div_disabled();
`endif
      test_rd_zero();
      test_start_held();
      test_back_to_back();
      test_reset_mid_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
